sprite_slot_scheduler: RTL and testbench
========================================

Name: sprite_slot_scheduler

Overview:
- Shares one synchronous sprite ROM read port among 4 on-screen sprite slots, such as score text, labels and icons.
- Per pixel: decides which slot covers (hc, vc), computes that slot's ROM address with 4x pixel scaling, and returns the sprite colour.
- Slot positions and enables are double-buffered and committed at frame start, so a sprite never tears mid-frame.
- Sits between the VGA timing counters and the colour mux.

Parameters:
- NUM_SLOTS, 4, number of sprite slots. Fixed at 4; cfg_idx is 2 bits.
- SPR_W, 22, sprite width in source texels.
- SPR_H, 5, sprite height in source texels.
- SCALE_LOG2, 2, screen pixels per texel = 1<<SCALE_LOG2 in each axis.
- ADDR_W, 9, ROM address width. Must satisfy NUM_SLOTS*SPR_W*SPR_H <= 2^ADDR_W.

Ports:
- CLK  in  1  system/pixel clock.
- RST  in  1  asynchronous, active-high reset.
- pix_en  in  1  pixel strobe; hc/vc are sampled only when high.
- hc  in  10  horizontal pixel counter.
- vc  in  10  vertical pixel counter.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- cfg_we  in  1  shadow register write strobe.
- cfg_idx  in  2  slot index for the write.
- cfg_en  in  1  slot enable value to write.
- cfg_x  in  10  slot left edge to write, in screen pixels.
- cfg_y  in  10  slot top edge to write, in screen pixels.
- rom_addr  out  ADDR_W  address to the shared sprite ROM.
- rom_data  in  4  ROM data; valid the cycle after rom_addr.
- pixel  out  4  resolved sprite colour; 0 = transparent/background.
- pixel_valid  out  1  pixel corresponds to a sampled pix_en cycle.
- hit_slot  out  2  winning slot index, meaningful when hit is high.
- hit  out  1  some enabled slot covers the pixel.
- commit_pulse  out  1  one-cycle pulse when shadow is copied to active.

Behaviour:
- Reset (asynchronous, RST=1):
  - all shadow and active x/y = 0, enables = 0, pending = 0;
  - rom_addr = 0, pixel = 0, pixel_valid = 0, hit = 0, hit_slot = 0, commit_pulse = 0.
  - Reset mid-frame or mid-pipeline flushes all in-flight pixels; no pixel_valid until a new pix_en.
- Config writes:
  - cfg_we writes cfg_en/cfg_x/cfg_y into shadow[cfg_idx] and sets pending.
  - Active registers never change except at a commit.
- Commit FSM, states IDLE and PENDING:
  - IDLE --cfg_we--> PENDING.
  - PENDING --frame_start--> copy every shadow slot to active, assert commit_pulse for 1 cycle, return to IDLE.
  - frame_start in IDLE: no copy, no pulse.
- Write and frame_start in the same cycle:
  - the commit copies shadow values from before that edge;
  - the concurrent write lands in shadow and leaves the FSM in PENDING for the next frame.
- Hit test, slot i, on the cycle-N sample where pix_en=1:
  - covered iff en_i and x_i <= hc < x_i + (SPR_W<<SCALE_LOG2) and y_i <= vc < y_i + (SPR_H<<SCALE_LOG2).
  - Bounds are computed in 11 bits, so sprites near the right/bottom edge clip and never wrap to coordinate 0.
- Priority:
  - lowest slot index wins when slots overlap; only one ROM read per pixel.
  - A transparent texel (0) of the winner shows background. There is no fall-through to lower-priority slots.
- Address: rom_addr = i*SPR_W*SPR_H + ((vc - y_i)>>SCALE_LOG2)*SPR_W + ((hc - x_i)>>SCALE_LOG2).
- Pipeline timing (free-running; valid bit tracks pix_en):
  - cycle N: hc/vc sampled with pix_en=1.
  - cycle N+1: rom_addr valid.
  - cycle N+2: rom_data valid.
  - cycle N+3: pixel, pixel_valid, hit, hit_slot registered and valid. Total latency is 3 cycles.
- No hit: rom_addr holds its previous value; in cycle N+3, pixel = 0, hit = 0, pixel_valid = 1.
- pix_en low: the stage's valid bit is 0; pixel_valid = 0 three cycles later and pixel holds its last value.
- Back-to-back pix_en on every cycle is supported at full throughput.

Decomposition:
- Shared package holds:
  - SPR_W, SPR_H, SCALE_LOG2, NUM_SLOTS, SLOT_DEPTH = SPR_W*SPR_H;
  - the slot config record type {en, x[9:0], y[9:0]}.
- Natural sub-module: sprite_slot_hit. Per slot, it does the window compare and local texel coordinate/offset computation; it is instantiated NUM_SLOTS times.
- Priority encode, pipeline and commit FSM stay in the top level.

Test Plan:
- Reset, then pix_en at hc=100/vc=50 with no config -> pixel_valid=1 at N+3, hit=0, pixel=0, commit_pulse never asserted.
- Write slot0 en=1 x=100 y=40, then frame_start, then sample hc=105/vc=45 -> commit_pulse 1 cycle; at N+1, rom_addr = 1*22+1 = 23; rom_data=0xA driven at N+2 -> pixel=0xA, hit_slot=0 at N+3.
- Slot0 and slot2 both cover hc=120/vc=44 (slot2 x=110 y=40) -> hit_slot=0, rom_addr from slot0 range (<110); with slot0 disabled -> rom_addr = 220+1*22+2 = 244, hit_slot=2.
- Edge clipping, slot1 x=1000 y=0: hc=1023 hits with lx=5; hc=0/vc=0 -> hit=0 (no wrap).
- Config write with no frame_start, then scan -> old position still used; write coincident with frame_start -> old shadow committed, commit_pulse again on the next frame_start.
- RST asserted while 3 pixels are in flight -> pixel_valid=0 immediately; the next valid pixel appears 3 cycles after the first post-reset pix_en.

Source files
------------

// File: rtl/sprite_slot_scheduler_pkg.sv
// Shared constants and types for the sprite slot scheduler.
package sprite_slot_scheduler_pkg;

    localparam int NUM_SLOTS  = 4;
    localparam int SPR_W      = 22;
    localparam int SPR_H      = 5;
    localparam int SCALE_LOG2 = 2;
    localparam int ADDR_W     = 9;
    localparam int SLOT_DEPTH = SPR_W * SPR_H;

    // On-screen window size of one sprite, kept at 11 bits so edge sprites clip
    localparam logic [10:0] WIN_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] WIN_H = 11'(SPR_H << SCALE_LOG2);

    // One slot's placement: enable plus top-left corner in screen pixels
    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
    } slot_cfg_t;

endpackage

// File: rtl/sprite_slot_scheduler_if.sv
// Pixel, config, ROM and result signals of the sprite slot scheduler.
interface sprite_slot_scheduler_if;
    import sprite_slot_scheduler_pkg::*;

    logic              pix_en;
    logic [9:0]        hc;
    logic [9:0]        vc;
    logic              frame_start;
    logic              cfg_we;
    logic [1:0]        cfg_idx;
    logic              cfg_en;
    logic [9:0]        cfg_x;
    logic [9:0]        cfg_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        pixel;
    logic              pixel_valid;
    logic [1:0]        hit_slot;
    logic              hit;
    logic              commit_pulse;

    modport slave (
        input  pix_en, hc, vc, frame_start,
        input  cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y,
        input  rom_data,
        output rom_addr, pixel, pixel_valid, hit_slot, hit, commit_pulse
    );

    modport master (
        output pix_en, hc, vc, frame_start,
        output cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y,
        output rom_data,
        input  rom_addr, pixel, pixel_valid, hit_slot, hit, commit_pulse
    );

endinterface

// File: rtl/sprite_slot_hit.sv
// Window test and ROM address for one sprite slot at the current pixel.
module sprite_slot_hit
    import sprite_slot_scheduler_pkg::*;
#(
    parameter int SLOT_IDX = 0
) (
    input  slot_cfg_t         cfg,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    output logic              covered,
    output logic [ADDR_W-1:0] addr
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [9:0]  lx;
    logic [9:0]  ly;

    // Compare against 11-bit bounds, then scale the local offset down to texels
    always_comb begin
        x_end   = {1'b0, cfg.x} + WIN_W;
        y_end   = {1'b0, cfg.y} + WIN_H;
        covered = cfg.en
                  && (hc >= cfg.x) && ({1'b0, hc} < x_end)
                  && (vc >= cfg.y) && ({1'b0, vc} < y_end);
        dx      = hc - cfg.x;
        dy      = vc - cfg.y;
        lx      = dx >> SCALE_LOG2;
        ly      = dy >> SCALE_LOG2;
        // Only meaningful when covered; otherwise the top level ignores it
        addr    = ADDR_W'(SLOT_IDX * SLOT_DEPTH + int'(ly) * SPR_W + int'(lx));
    end

endmodule

// File: rtl/sprite_slot_scheduler.sv
// Arbitrates 4 sprite slots onto one synchronous ROM port, 3-cycle pixel pipeline,
// with shadow/active slot registers committed at frame start.
module sprite_slot_scheduler
    import sprite_slot_scheduler_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    sprite_slot_scheduler_if.slave  bus
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    slot_cfg_t         shadow_q [NUM_SLOTS];
    slot_cfg_t         shadow_d [NUM_SLOTS];
    slot_cfg_t         active_q [NUM_SLOTS];
    slot_cfg_t         active_d [NUM_SLOTS];
    logic [0:0]        state_q, state_d;
    logic              commit_pulse_q, commit_pulse_d;

    logic [NUM_SLOTS-1:0] slot_cov;
    logic [ADDR_W-1:0]    slot_addr [NUM_SLOTS];
    logic                 any_hit;
    logic [1:0]           win_idx;
    logic [ADDR_W-1:0]    win_addr;

    // Stage 1: address issued to the ROM
    logic              v1_q, v1_d;
    logic              hit1_q, hit1_d;
    logic [1:0]        slot1_q, slot1_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    // Stage 2: waiting for ROM data
    logic              v2_q, v2_d;
    logic              hit2_q, hit2_d;
    logic [1:0]        slot2_q, slot2_d;
    // Stage 3: resolved outputs
    logic              pixel_valid_q, pixel_valid_d;
    logic [3:0]        pixel_q, pixel_d;
    logic              hit_q, hit_d;
    logic [1:0]        hit_slot_q, hit_slot_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            sprite_slot_hit #(.SLOT_IDX(gi)) u_hit (
                .cfg     (active_q[gi]),
                .hc      (bus.hc),
                .vc      (bus.vc),
                .covered (slot_cov[gi]),
                .addr    (slot_addr[gi])
            );
        end
    endgenerate

    // Shadow writes and the IDLE/PENDING commit machine
    always_comb begin
        shadow_d       = shadow_q;
        active_d       = active_q;
        state_d        = state_q;
        commit_pulse_d = 1'b0;
        if (bus.cfg_we) begin
            shadow_d[bus.cfg_idx].en = bus.cfg_en;
            shadow_d[bus.cfg_idx].x  = bus.cfg_x;
            shadow_d[bus.cfg_idx].y  = bus.cfg_y;
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_we) begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                if (bus.frame_start) begin
                    // Copy pre-edge shadow; a write in this same cycle waits for the next frame
                    active_d       = shadow_q;
                    commit_pulse_d = 1'b1;
                    state_d        = bus.cfg_we ? ST_PENDING : ST_IDLE;
                end
            end
        endcase
    end

    // Priority encode: scanning downwards leaves the lowest covering slot as winner
    always_comb begin
        any_hit  = 1'b0;
        win_idx  = 2'd0;
        win_addr = rom_addr_q;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_cov[i]) begin
                any_hit  = 1'b1;
                win_idx  = 2'(i);
                win_addr = slot_addr[i];
            end
        end
    end

    // Pixel pipeline next-state; rom_addr only moves on a hit
    always_comb begin
        v1_d       = bus.pix_en;
        hit1_d     = bus.pix_en & any_hit;
        slot1_d    = win_idx;
        rom_addr_d = rom_addr_q;
        if (bus.pix_en && any_hit) begin
            rom_addr_d = win_addr;
        end
        v2_d    = v1_q;
        hit2_d  = hit1_q;
        slot2_d = slot1_q;
        pixel_valid_d = v2_q;
        pixel_d       = pixel_q;
        hit_d         = hit_q;
        hit_slot_d    = hit_slot_q;
        if (v2_q) begin
            // Winner's transparent texel shows background; no fall-through
            pixel_d    = hit2_q ? bus.rom_data : 4'd0;
            hit_d      = hit2_q;
            hit_slot_d = slot2_q;
        end
    end

    // All state registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            state_q        <= ST_IDLE;
            commit_pulse_q <= 1'b0;
            v1_q           <= 1'b0;
            hit1_q         <= 1'b0;
            slot1_q        <= 2'd0;
            rom_addr_q     <= '0;
            v2_q           <= 1'b0;
            hit2_q         <= 1'b0;
            slot2_q        <= 2'd0;
            pixel_valid_q  <= 1'b0;
            pixel_q        <= 4'd0;
            hit_q          <= 1'b0;
            hit_slot_q     <= 2'd0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            state_q        <= state_d;
            commit_pulse_q <= commit_pulse_d;
            v1_q           <= v1_d;
            hit1_q         <= hit1_d;
            slot1_q        <= slot1_d;
            rom_addr_q     <= rom_addr_d;
            v2_q           <= v2_d;
            hit2_q         <= hit2_d;
            slot2_q        <= slot2_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_q        <= pixel_d;
            hit_q          <= hit_d;
            hit_slot_q     <= hit_slot_d;
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.pixel        = pixel_q;
    assign bus.pixel_valid  = pixel_valid_q;
    assign bus.hit          = hit_q;
    assign bus.hit_slot     = hit_slot_q;
    assign bus.commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_sprite_slot_scheduler.sv
// Directed vector bench for sprite_slot_scheduler; ROM model returns addr[3:0].
module tb_sprite_slot_scheduler;

    typedef struct {
        int         phase;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       exp_hit;
        logic [1:0] exp_slot;
        logic [8:0] exp_addr;
        logic [3:0] exp_pix;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   pulse_cnt = 0;
    logic [8:0] last_addr = 9'd0;
    vec_t tbl [20];

    sprite_slot_scheduler_if bus ();

    sprite_slot_scheduler u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the address, content = low nibble of address
    always @(posedge clk) bus.rom_data <= bus.rom_addr[3:0];

    // Count commit pulses (each lasts exactly one cycle, so one negedge sees it)
    always @(negedge clk) if (bus.commit_pulse) pulse_cnt++;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_en = en; bus.cfg_x = x; bus.cfg_y = y;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        $display("cfg slot=%0d en=%0b x=%0d y=%0d", idx, en, x, y);
    endtask

    task automatic do_frame(input logic exp_pulse, input logic wr, input logic [1:0] idx,
                            input logic en, input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.cfg_we = wr; bus.cfg_idx = idx; bus.cfg_en = en; bus.cfg_x = x; bus.cfg_y = y;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.cfg_we = 1'b0;
        chk("commit_pulse", int'(bus.commit_pulse), int'(exp_pulse));
        @(negedge clk);
        chk("commit_pulse_width", int'(bus.commit_pulse), 0);
        $display("frame_start write=%0b expected_pulse=%0b", wr, exp_pulse);
    endtask

    task automatic apply_vec(input vec_t v);
        logic [8:0] exp_a;
        @(negedge clk);
        bus.pix_en = 1'b1; bus.hc = v.hc; bus.vc = v.vc;
        @(negedge clk);
        bus.pix_en = 1'b0;
        exp_a = v.exp_hit ? v.exp_addr : last_addr;
        chk("rom_addr", int'(bus.rom_addr), int'(exp_a));
        last_addr = exp_a;
        @(negedge clk);
        chk("pixel_valid_early", int'(bus.pixel_valid), 0);
        @(negedge clk);
        chk("pixel_valid", int'(bus.pixel_valid), 1);
        chk("hit", int'(bus.hit), int'(v.exp_hit));
        if (v.exp_hit) chk("hit_slot", int'(bus.hit_slot), int'(v.exp_slot));
        chk("pixel", int'(bus.pixel), v.exp_hit ? int'(v.exp_pix) : 0);
        $display("pix hc=%0d vc=%0d addr=%0d pixel=%h hit=%b slot=%0d",
                 v.hc, v.vc, bus.rom_addr, bus.pixel, bus.hit, bus.hit_slot);
    endtask

    task automatic do_phase(input int p);
        case (p)
            1: begin
                chk("no_commit_while_idle", pulse_cnt, 0);
                cfg_write(2'd0, 1'b1, 10'd100, 10'd40);
                do_frame(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
            end
            2: begin
                cfg_write(2'd2, 1'b1, 10'd110, 10'd40);
                do_frame(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
            end
            3: begin
                cfg_write(2'd0, 1'b0, 10'd100, 10'd40);
                do_frame(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
            end
            4: begin
                cfg_write(2'd1, 1'b1, 10'd1000, 10'd0);
                do_frame(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
            end
            5: cfg_write(2'd1, 1'b1, 10'd500, 10'd0);
            6: do_frame(1'b1, 1'b1, 2'd1, 1'b1, 10'd600, 10'd0);
            7: begin
                do_frame(1'b1, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
                do_frame(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [9:0] bb_hc   [4];
        logic [8:0] bb_addr [4];
        logic [3:0] bb_pix  [4];
        logic       bb_hit  [4];
        int         cur_phase;

        //          phase  hc       vc     hit   slot  addr     pixel
        tbl[0]  = '{0, 10'd100,  10'd50, 1'b0, 2'd0, 9'd0,   4'h0};
        tbl[1]  = '{1, 10'd105,  10'd45, 1'b1, 2'd0, 9'd23,  4'h7};
        tbl[2]  = '{1, 10'd100,  10'd40, 1'b1, 2'd0, 9'd0,   4'h0};
        tbl[3]  = '{1, 10'd187,  10'd59, 1'b1, 2'd0, 9'd109, 4'hD};
        tbl[4]  = '{1, 10'd188,  10'd45, 1'b0, 2'd0, 9'd0,   4'h0};
        tbl[5]  = '{1, 10'd105,  10'd60, 1'b0, 2'd0, 9'd0,   4'h0};
        tbl[6]  = '{1, 10'd99,   10'd45, 1'b0, 2'd0, 9'd0,   4'h0};
        tbl[7]  = '{2, 10'd120,  10'd44, 1'b1, 2'd0, 9'd27,  4'hB};
        tbl[8]  = '{2, 10'd197,  10'd44, 1'b1, 2'd2, 9'd263, 4'h7};
        tbl[9]  = '{3, 10'd120,  10'd44, 1'b1, 2'd2, 9'd244, 4'h4};
        tbl[10] = '{4, 10'd1023, 10'd0,  1'b1, 2'd1, 9'd115, 4'h3};
        tbl[11] = '{4, 10'd0,    10'd0,  1'b0, 2'd0, 9'd0,   4'h0};
        tbl[12] = '{4, 10'd1023, 10'd19, 1'b1, 2'd1, 9'd203, 4'hB};
        tbl[13] = '{4, 10'd1023, 10'd20, 1'b0, 2'd0, 9'd0,   4'h0};
        tbl[14] = '{5, 10'd1023, 10'd0,  1'b1, 2'd1, 9'd115, 4'h3};
        tbl[15] = '{5, 10'd500,  10'd0,  1'b0, 2'd0, 9'd0,   4'h0};
        tbl[16] = '{6, 10'd500,  10'd0,  1'b1, 2'd1, 9'd110, 4'hE};
        tbl[17] = '{6, 10'd1023, 10'd0,  1'b0, 2'd0, 9'd0,   4'h0};
        tbl[18] = '{7, 10'd600,  10'd4,  1'b1, 2'd1, 9'd132, 4'h4};
        tbl[19] = '{7, 10'd500,  10'd0,  1'b0, 2'd0, 9'd0,   4'h0};

        bb_hc   = '{10'd110, 10'd114, 10'd118, 10'd200};
        bb_addr = '{9'd220, 9'd221, 9'd222, 9'd222};
        bb_pix  = '{4'hC, 4'hD, 4'hE, 4'h0};
        bb_hit  = '{1'b1, 1'b1, 1'b1, 1'b0};

        bus.pix_en = 1'b0; bus.hc = '0; bus.vc = '0; bus.frame_start = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0; bus.cfg_x = '0; bus.cfg_y = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", int'(bus.rom_addr), 0);
        chk("rst_pixel", int'(bus.pixel), 0);
        chk("rst_pixel_valid", int'(bus.pixel_valid), 0);
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_hit_slot", int'(bus.hit_slot), 0);
        chk("rst_commit_pulse", int'(bus.commit_pulse), 0);
        rst = 1'b0;

        // frame_start with nothing pending must not commit
        do_frame(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);

        cur_phase = 0;
        for (int i = 0; i < 20; i++) begin
            if (tbl[i].phase != cur_phase) begin
                cur_phase = tbl[i].phase;
                do_phase(cur_phase);
            end
            apply_vec(tbl[i]);
        end

        // Back-to-back pixels at full throughput through slot 2
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) chk("bb_rom_addr", int'(bus.rom_addr), int'(bb_addr[k-1]));
            if (k >= 3) begin
                chk("bb_pixel_valid", int'(bus.pixel_valid), 1);
                chk("bb_hit", int'(bus.hit), int'(bb_hit[k-3]));
                chk("bb_pixel", int'(bus.pixel), int'(bb_pix[k-3]));
                $display("bb pix %0d pixel=%h hit=%b", k - 3, bus.pixel, bus.hit);
            end
            if (k < 4) begin
                bus.pix_en = 1'b1; bus.hc = bb_hc[k]; bus.vc = 10'd40;
            end else begin
                bus.pix_en = 1'b0;
            end
        end
        @(negedge clk);
        chk("bb_pixel_valid_end", int'(bus.pixel_valid), 0);
        last_addr = 9'd222;

        // Leave a write pending, then reset with pixels in flight
        cfg_write(2'd3, 1'b1, 10'd0, 10'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.pix_en = 1'b1; bus.hc = 10'd110; bus.vc = 10'd40;
        end
        chk("pre_rst_pixel_valid", int'(bus.pixel_valid), 1);
        #2 rst = 1'b1;
        bus.pix_en = 1'b0;
        #1;
        chk("rst_flush_pixel_valid", int'(bus.pixel_valid), 0);
        chk("rst_flush_rom_addr", int'(bus.rom_addr), 0);
        chk("rst_flush_pixel", int'(bus.pixel), 0);
        @(negedge clk);
        rst = 1'b0;
        last_addr = 9'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_idle_valid", int'(bus.pixel_valid), 0);
        end
        // Reset dropped the pending commit and all active slots
        do_frame(1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 10'd0);
        apply_vec('{0, 10'd110, 10'd40, 1'b0, 2'd0, 9'd0, 4'h0});
        apply_vec('{0, 10'd0, 10'd0, 1'b0, 2'd0, 9'd0, 4'h0});

        chk("total_commit_pulses", pulse_cnt, 6);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
